// File: rtl/seg_capture_encoder.sv
// seg_capture_encoder
// Watches a multiplexed active-low 7-segment bus plus its one-hot digit
// selects and recovers the hex nibble shown on each digit. A digit is taken
// once its (select, pattern) pair has been stable for STABLE_CYCLES samples.
module seg_capture_encoder #(
   parameter int NUM_DIGITS     = 4,
   parameter int STABLE_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   dig_sel,
   output logic                    busy,
   output logic [4*NUM_DIGITS-1:0] value,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic [NUM_DIGITS-1:0]   digit_blank,
   output logic                    done,
   output logic                    err,
   output logic [2:0]              err_digit,
   output logic                    timeout
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
   localparam logic [TW-1:0] TO_C     = TW'(TIMEOUT_CYCLES);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_CAPTURE = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;

   logic [1:0]              r_state;
   logic [NUM_DIGITS-1:0]   r_sel, r_prev_sel;
   logic [6:0]              r_seg, r_prev_seg;
   logic [CW-1:0]           r_cnt;
   logic [TW-1:0]           r_to;
   logic [4*NUM_DIGITS-1:0] r_value;
   logic [NUM_DIGITS-1:0]   r_valid, r_blank;
   logic                    r_err, r_timeout;
   logic [2:0]              r_err_digit;

   logic                    w_onehot, w_same, w_reach, w_accept, w_any_take;
   logic [CW-1:0]           w_cnt_next;
   logic [2:0]              w_idx;
   logic [NUM_DIGITS-1:0]   w_take, w_valid_next;
   logic [5:0]              w_dec;
   logic                    w_legal, w_blank_pat;
   logic [3:0]              w_nib;

   // Pattern lookup: returns {legal, blank, nibble}; anything unlisted is illegal.
   function automatic logic [5:0] decode(input logic [6:0] p);
      case (p)
         7'h01: decode = 6'b10_0000;
         7'h4F: decode = 6'b10_0001;
         7'h12: decode = 6'b10_0010;
         7'h06: decode = 6'b10_0011;
         7'h4C: decode = 6'b10_0100;
         7'h24: decode = 6'b10_0101;
         7'h20: decode = 6'b10_0110;
         7'h0F: decode = 6'b10_0111;
         7'h00: decode = 6'b10_1000;
         7'h04: decode = 6'b10_1001;
         7'h08: decode = 6'b10_1010;
         7'h60: decode = 6'b10_1011;
         7'h31: decode = 6'b10_1100;
         7'h42: decode = 6'b10_1101;
         7'h30: decode = 6'b10_1110;
         7'h38: decode = 6'b10_1111;
         7'h7F: decode = 6'b01_0000;
         default: decode = 6'b00_0000;
      endcase
   endfunction

   assign w_dec       = decode(r_seg);
   assign w_legal     = w_dec[5];
   assign w_blank_pat = w_dec[4];
   assign w_nib       = w_dec[3:0];

   assign w_onehot = (r_sel != '0) && ((r_sel & (r_sel - 1'b1)) == '0);
   assign w_same   = (r_sel == r_prev_sel) && (r_seg == r_prev_seg);

   // Counter reaches the threshold on this edge (first time only; saturation does not re-trigger).
   assign w_reach  = w_onehot && (w_same ? (r_cnt == STABLE_C - 1'b1) : (STABLE_C == CW'(1)));
   assign w_accept = (r_state == S_CAPTURE) && w_reach;

   // Stability counter next value: zero on bad select, restart at 1 whenever the sample changes.
   always_comb begin
      w_cnt_next = '0;
      if (w_onehot) begin
         if (w_same)
            w_cnt_next = (r_cnt == STABLE_C) ? r_cnt : r_cnt + 1'b1;
         else
            w_cnt_next = CW'(1);
      end
   end

   // Index of the selected digit (only meaningful when the select is one-hot).
   always_comb begin
      w_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (r_sel[i]) w_idx = 3'(i);
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_take
         assign w_take[gi] = w_accept & r_sel[gi] & ~r_valid[gi];
      end
   endgenerate

   assign w_any_take   = |w_take;
   assign w_valid_next = r_valid | w_take;

   // Input sampling stage: one register for the bus, one more for the previous sample.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sel      <= '0;
         r_seg      <= '0;
         r_prev_sel <= '0;
         r_prev_seg <= '0;
      end else begin
         r_sel      <= dig_sel;
         r_seg      <= seg_n;
         r_prev_sel <= r_sel;
         r_prev_seg <= r_seg;
      end
   end

   // Frame control, digit acceptance, and event pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_to        <= '0;
         r_value     <= '0;
         r_valid     <= '0;
         r_blank     <= '0;
         r_err       <= 1'b0;
         r_err_digit <= '0;
         r_timeout   <= 1'b0;
      end else begin
         r_err     <= 1'b0;
         r_timeout <= 1'b0;
         r_cnt     <= '0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state     <= S_CAPTURE;
                  r_value     <= '0;
                  r_valid     <= '0;
                  r_blank     <= '0;
                  r_to        <= '0;
                  r_err_digit <= '0;
               end
            end
            S_CAPTURE: begin
               r_cnt <= w_cnt_next;
               r_to  <= r_to + 1'b1;
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  if (w_take[i]) begin
                     r_valid[i]       <= 1'b1;
                     r_blank[i]       <= w_blank_pat;
                     r_value[4*i +: 4] <= w_legal ? w_nib : 4'h0;
                  end
               end
               if (w_any_take && !w_legal && !w_blank_pat) begin
                  r_err       <= 1'b1;
                  r_err_digit <= w_idx;
               end
               // A frame completing on the timeout edge still finishes as done.
               if (&r_valid)
                  r_state <= S_DONE;
               else if ((r_to + 1'b1 == TO_C) && !(&w_valid_next)) begin
                  r_state   <= S_IDLE;
                  r_timeout <= 1'b1;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy        = (r_state == S_CAPTURE);
   assign done        = (r_state == S_DONE);
   assign value       = r_value;
   assign digit_valid = r_valid;
   assign digit_blank = r_blank;
   assign err         = r_err;
   assign err_digit   = r_err_digit;
   assign timeout     = r_timeout;

endmodule

// File: tb/tb_seg_capture_encoder.sv
// Directed bench for seg_capture_encoder (4 digits, 8-sample stability, 100-cycle timeout).
module tb_seg_capture_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [6:0]  seg_n;
   logic [3:0]  dig_sel;
   logic        busy, done, err, timeout;
   logic [15:0] value;
   logic [3:0]  digit_valid, digit_blank;
   logic [2:0]  err_digit;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0, err_cnt = 0, to_cnt = 0, to_cyc = 0;

   seg_capture_encoder #(
      .NUM_DIGITS(4), .STABLE_CYCLES(8), .TIMEOUT_CYCLES(100)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .seg_n(seg_n), .dig_sel(dig_sel),
      .busy(busy), .value(value), .digit_valid(digit_valid), .digit_blank(digit_blank),
      .done(done), .err(err), .err_digit(err_digit), .timeout(timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Pulse monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (timeout) begin
         to_cnt++;
         to_cyc = cyc;
      end
   end

   // All drive tasks are entered and left at a falling edge.
   task automatic show(input int d, input logic [6:0] pat, input int n);
      dig_sel = 4'(1 << d);
      seg_n   = pat;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; dig_sel = 4'h0; seg_n = 7'h7F;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (value !== 16'h0) begin errors++; $display("FAIL reset_value got %h exp 0000", value); end
      checks++; if ({digit_valid, digit_blank} !== 8'h0) begin errors++; $display("FAIL reset_flags got %h exp 00", {digit_valid, digit_blank}); end
      checks++; if ({done, err, timeout, err_digit} !== 6'h0) begin errors++; $display("FAIL reset_events got %b exp 000000", {done, err, timeout, err_digit}); end
   endtask

   task automatic test_basic();
      int d0 = done_cnt;
      pulse_start();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_up got %b exp 1", busy); end
      show(0, 7'h12, 10); show(1, 7'h4F, 10); show(2, 7'h01, 10); show(3, 7'h00, 10);
      repeat (3) @(negedge clk);
      checks++; if (value !== 16'h8012) begin errors++; $display("FAIL basic_value got %h exp 8012", value); end
      checks++; if (digit_valid !== 4'hF) begin errors++; $display("FAIL basic_valid got %h exp f", digit_valid); end
      checks++; if (digit_blank !== 4'h0) begin errors++; $display("FAIL basic_blank got %h exp 0", digit_blank); end
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", done_cnt - d0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_down got %b exp 0", busy); end
      $display("basic frame: value=%h valid=%h", value, digit_valid);
   endtask

   task automatic test_blank();
      int d0 = done_cnt;
      pulse_start();
      show(0, 7'h24, 10); show(1, 7'h4C, 10); show(2, 7'h7F, 10); show(3, 7'h06, 10);
      repeat (3) @(negedge clk);
      checks++; if (digit_blank !== 4'b0100) begin errors++; $display("FAIL blank_bits got %b exp 0100", digit_blank); end
      checks++; if (value !== 16'h3045) begin errors++; $display("FAIL blank_value got %h exp 3045", value); end
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL blank_done_count got %0d exp 1", done_cnt - d0); end
      $display("blank frame: value=%h blank=%b", value, digit_blank);
   endtask

   task automatic test_err();
      int d0 = done_cnt;
      int e0 = err_cnt;
      pulse_start();
      show(0, 7'h12, 10); show(1, 7'h55, 10); show(2, 7'h4F, 10); show(3, 7'h0F, 10);
      repeat (3) @(negedge clk);
      checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL err_count got %0d exp 1", err_cnt - e0); end
      checks++; if (err_digit !== 3'd1) begin errors++; $display("FAIL err_digit got %0d exp 1", err_digit); end
      checks++; if (value !== 16'h7102) begin errors++; $display("FAIL err_value got %h exp 7102", value); end
      checks++; if (digit_valid !== 4'hF) begin errors++; $display("FAIL err_valid got %h exp f", digit_valid); end
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL err_done_count got %0d exp 1", done_cnt - d0); end
      $display("error frame: value=%h err_digit=%0d", value, err_digit);
   endtask

   task automatic test_back_to_back();
      pulse_start();
      show(0, 7'h20, 10); show(1, 7'h38, 10); show(2, 7'h30, 10); show(3, 7'h04, 10);
      // Last digit accepted two edges ago; done is visible now.
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done_timing got %b exp 1", done); end
      checks++; if (value !== 16'h9EF6) begin errors++; $display("FAIL b2b_value got %h exp 9ef6", value); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_width got %b exp 0", done); end
      pulse_start();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy got %b exp 1", busy); end
      checks++; if (digit_valid !== 4'h0) begin errors++; $display("FAIL b2b_restart_valid got %h exp 0", digit_valid); end
      show(0, 7'h4F, 10); show(1, 7'h12, 10); show(2, 7'h06, 10); show(3, 7'h4C, 10);
      repeat (3) @(negedge clk);
      checks++; if (value !== 16'h4321) begin errors++; $display("FAIL b2b_second_value got %h exp 4321", value); end
      $display("back-to-back frames: second value=%h", value);
   endtask

   task automatic test_onehot();
      int d0 = done_cnt;
      pulse_start();
      dig_sel = 4'b0011; seg_n = 7'h12;
      repeat (20) @(negedge clk);
      checks++; if (digit_valid !== 4'h0) begin errors++; $display("FAIL onehot_none got %h exp 0", digit_valid); end
      show(0, 7'h08, 10);
      pulse_start();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midstart_busy got %b exp 1", busy); end
      checks++; if (digit_valid !== 4'b0001) begin errors++; $display("FAIL midstart_valid got %b exp 0001", digit_valid); end
      show(1, 7'h60, 10); show(2, 7'h31, 10); show(3, 7'h42, 10);
      repeat (3) @(negedge clk);
      checks++; if (value !== 16'hDCBA) begin errors++; $display("FAIL onehot_value got %h exp dcba", value); end
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL onehot_done_count got %0d exp 1", done_cnt - d0); end
      $display("one-hot/mid-start frame: value=%h", value);
   endtask

   task automatic test_timeout();
      int d0 = done_cnt;
      int t0 = to_cnt;
      int start_cyc;
      int waited = 0;
      pulse_start();
      start_cyc = cyc;
      show(0, 7'h12, 7);
      show(1, 7'h4F, 10);
      for (int k = 0; k < 8; k++) show(2, (k % 2 == 0) ? 7'h01 : 7'h4F, 3);
      dig_sel = 4'h0;
      while (to_cnt == t0 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checks++; if (to_cnt - t0 !== 1) begin errors++; $display("FAIL timeout_seen got %0d exp 1", to_cnt - t0); end
      checks++; if (to_cyc - start_cyc !== 100) begin errors++; $display("FAIL timeout_cycle got %0d exp 100", to_cyc - start_cyc); end
      repeat (2) @(negedge clk);
      checks++; if (digit_valid !== 4'b0010) begin errors++; $display("FAIL timeout_valid got %b exp 0010", digit_valid); end
      checks++; if (value !== 16'h0010) begin errors++; $display("FAIL timeout_value got %h exp 0010", value); end
      checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL timeout_no_done got %0d exp 0", done_cnt - d0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b exp 0", busy); end
      $display("timeout frame: after %0d cycles value=%h valid=%b", to_cyc - start_cyc, value, digit_valid);
   endtask

   task automatic test_reset_mid();
      int d0 = done_cnt;
      int t0 = to_cnt;
      pulse_start();
      show(0, 7'h12, 10); show(1, 7'h4F, 10);
      checks++; if (digit_valid !== 4'b0011) begin errors++; $display("FAIL rstmid_pre_valid got %b exp 0011", digit_valid); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if ({busy, value, digit_valid, digit_blank, done, err, err_digit, timeout} !== 32'h0) begin
         errors++; $display("FAIL rstmid_clear got busy=%b value=%h valid=%b", busy, value, digit_valid);
      end
      show(2, 7'h01, 12);
      checks++; if (digit_valid !== 4'h0) begin errors++; $display("FAIL rstmid_idle_valid got %b exp 0000", digit_valid); end
      checks++; if ((done_cnt - d0) + (to_cnt - t0) !== 0) begin errors++; $display("FAIL rstmid_no_pulse got %0d exp 0", (done_cnt - d0) + (to_cnt - t0)); end
      $display("reset mid-frame: valid=%b busy=%b", digit_valid, busy);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_blank();
      test_err();
      test_back_to_back();
      test_onehot();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_capture_encoder.md
Name: seg_capture_encoder

Overview:
- Inverse of the hex-to-7-segment decoding path: watches a multiplexed, active-low 7-segment bus and its digit-select lines, and recovers the 4-bit hex value shown on each digit.
- Used for display self-test and for readback of the reaction-time value actually driven to the display.
- Each digit must hold a stable pattern for a programmable number of cycles before it is accepted.
- Reports per-digit value, blank and error status, plus frame-complete and timeout events.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 8, consecutive identical samples required to accept a digit (>=1).
- TIMEOUT_CYCLES, 65535, cycles allowed in CAPTURE before abort (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  single-cycle request to begin a capture frame.
- seg_n  in  7  segment bus, active-low; bit6 = seg a … bit0 = seg g.
- dig_sel  in  NUM_DIGITS  one-hot active-high digit select; bit i = digit i.
- busy  out  1  high while in CAPTURE.
- value  out  4*NUM_DIGITS  decoded nibbles; digit i at [4i+3:4i].
- digit_valid  out  NUM_DIGITS  digit i captured in the current frame.
- digit_blank  out  NUM_DIGITS  digit i captured as blank (7'h7F).
- done  out  1  one-cycle pulse: all digits captured.
- err  out  1  one-cycle pulse: an illegal pattern was accepted.
- err_digit  out  3  index of the digit flagged by the last err; held until the next err or start.
- timeout  out  1  one-cycle pulse: frame aborted.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE. All outputs are 0, including value, valid, blank and err_digit. Stability counter is 0; previous-sample registers are 0.
- Legal pattern table (seg_n -> nibble):
  - 01->0, 4F->1, 12->2, 06->3, 4C->4, 24->5, 20->6, 0F->7
  - 00->8, 04->9, 08->A, 60->b, 31->C, 42->d, 30->E, 38->F
  - 7F = blank.
  - Any other pattern is illegal.
- States:
  - IDLE -> CAPTURE on start.
  - CAPTURE -> DONE when all digit_valid bits are 1.
  - CAPTURE -> IDLE on timeout.
  - DONE -> IDLE unconditionally after 1 cycle.
- Entering CAPTURE:
  - Clears digit_valid, digit_blank and value.
  - Clears the timeout counter and the stability counter.
  - busy goes high on the cycle after start is sampled.
- Sampling in CAPTURE, every cycle, with (dig_sel, seg_n) registered once (1-cycle input latency):
  - If dig_sel is not exactly one-hot, the counter is forced to 0.
  - Else, if the registered sample equals the previous registered sample, the counter increments, saturating at STABLE_CYCLES.
  - Else the counter loads 1.
- Acceptance:
  - A digit is accepted on the cycle the counter first reaches STABLE_CYCLES, and only if that digit's valid bit is 0. Already-captured digits are ignored until the next start.
  - Legal hex pattern: nibble written, valid bit set.
  - Blank pattern: nibble 0, valid and blank bits set.
  - Illegal pattern: nibble 0, valid bit set, err pulses on the same cycle, err_digit = index.
  - Accepted outputs are visible the cycle after the counter reaches STABLE_CYCLES.
- done:
  - Pulses in the DONE state, i.e. 1 cycle after the last digit_valid bit rises.
  - value, digit_valid and digit_blank then hold until the next start.
- Timeout:
  - The counter increments each CAPTURE cycle.
  - On reaching TIMEOUT_CYCLES: timeout pulses, busy drops, and partial results are retained. done does not pulse.
  - A frame that completes on the same cycle as timeout reports done, not timeout.
- start handling:
  - start while in CAPTURE or DONE is ignored.
  - start in IDLE on the cycle after a done or timeout pulse is accepted normally.
- Reset mid-frame: immediate return to IDLE with all outputs cleared; no done or timeout pulse.
- Digit-select changes mid-count: the counter restarts at 1 for the new digit, so partial stability never carries across digits.

Test Plan:
- Reset, then start. Drive digits 0..3 = 12, 4F, 01, 00 (seg_n hex), each held 10 cycles with STABLE_CYCLES=8 -> value=16'h8012, digit_valid=4'hF, digit_blank=0, done pulses once, busy low afterwards.
- Digit 2 shows 7F, others legal -> digit_blank=4'b0100, value[11:8]=0, done pulses.
- Digit 1 shows 7'h55 stable 8 cycles -> err pulses, err_digit=1, digit_valid[1]=1, value[7:4]=0; frame still completes with done.
- Digit 0 held only 7 cycles, then switched to digit 1 -> digit_valid[0] stays 0. Toggling seg_n every 3 cycles keeps the counter below 8 and no accept occurs. With TIMEOUT_CYCLES=100 and digit 3 never driven -> timeout pulses at cycle 100, partial value retained, no done.
- dig_sel=4'b0011 for 20 cycles -> no digit accepted. A second start mid-frame is ignored (busy stays high, valid bits not cleared).
- rst_n low for 1 cycle mid-frame after 2 digits captured -> all outputs 0 the next cycle, state IDLE, no done or timeout pulse.
